// File: rtl/reset_sequencer.sv
// Board reset synchroniser and stretcher with staggered per-domain release
// and a divided single-cycle clock-enable tick; soft reset re-runs the sequence.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 65535,
    parameter int NUM_DOMAINS = 3,
    parameter int STAGGER     = 16,
    parameter int DIV         = 1
) (
    input  logic                   CLK,
    input  logic                   RESETN,
    input  logic                   soft_rst_req,
    output logic [NUM_DOMAINS-1:0] rst_n_out,
    output logic                   ce,
    output logic                   ready,
    output logic                   busy
);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int STAG_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STAG_W-1:0]      STAG_LAST = STAG_W'(STAGGER - 1);
    localparam logic [DIV_W-1:0]       DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [NUM_DOMAINS-1:0] DOM_ONE   = NUM_DOMAINS'(1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STAGGER = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rstn_s;

    state_t                 state_reg, state_next;
    logic [HOLD_W-1:0]      hold_cnt_reg, hold_cnt_next;
    logic [STAG_W-1:0]      stag_cnt_reg, stag_cnt_next;
    logic [DIV_W-1:0]       div_cnt_reg, div_cnt_next;
    logic [NUM_DOMAINS-1:0] dom_reg, dom_next;
    logic                   ce_reg, ce_next;

    // Release-only synchroniser: assertion is asynchronous, deassertion is clocked.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rstn_s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_reg    <= ST_HOLD;
            hold_cnt_reg <= '0;
            stag_cnt_reg <= '0;
            div_cnt_reg  <= '0;
            dom_reg      <= '0;
            ce_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            stag_cnt_reg <= stag_cnt_next;
            div_cnt_reg  <= div_cnt_next;
            dom_reg      <= dom_next;
            ce_reg       <= ce_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        stag_cnt_next = stag_cnt_reg;
        div_cnt_next  = div_cnt_reg;
        dom_next      = dom_reg;
        ce_next       = 1'b0;

        if (rstn_s) begin
            if (soft_rst_req) begin
                state_next    = ST_HOLD;
                hold_cnt_next = '0;
                stag_cnt_next = '0;
                div_cnt_next  = '0;
                dom_next      = '0;
            end else begin
                case (state_reg)
                    ST_HOLD: begin
                        if (hold_cnt_reg == HOLD_LAST) begin
                            hold_cnt_next = '0;
                            stag_cnt_next = '0;
                            dom_next      = DOM_ONE;
                            state_next    = (NUM_DOMAINS == 1) ? ST_RUN : ST_STAGGER;
                        end else begin
                            hold_cnt_next = hold_cnt_reg + 1'b1;
                        end
                    end
                    ST_STAGGER: begin
                        if (stag_cnt_reg == STAG_LAST) begin
                            stag_cnt_next = '0;
                            // Domain bits form a thermometer code, so shift in the next one.
                            dom_next      = (dom_reg << 1) | DOM_ONE;
                            if (dom_next[NUM_DOMAINS-1]) begin
                                state_next = ST_RUN;
                            end
                        end else begin
                            stag_cnt_next = stag_cnt_reg + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        state_next = ST_RUN;
                    end
                    default: begin
                        state_next = ST_HOLD;
                    end
                endcase

                if (dom_reg[0]) begin
                    ce_next      = (div_cnt_reg == DIV_LAST);
                    div_cnt_next = (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
                end else begin
                    div_cnt_next = '0;
                end
            end
        end
    end

    assign rst_n_out = dom_reg;
    assign ce        = ce_reg;
    assign ready     = (state_reg == ST_RUN);
    assign busy      = (state_reg != ST_RUN);

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: three configurations checked against
// hand-derived edge timelines (E0 = first CLK edge after RESETN release).
module tb_reset_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn_a, resetn_b, resetn_c;
    logic       soft_a, soft_b, soft_c;
    logic [2:0] dom_a, dom_b;
    logic [0:0] dom_c;
    logic       ce_a, ce_b, ce_c;
    logic       ready_a, ready_b, ready_c;
    logic       busy_a, busy_b, busy_c;

    int errors = 0;
    int checks = 0;
    int e      = 0;

    reset_sequencer #(
        .SYNC_STAGES(2), .HOLD_CYCLES(4), .NUM_DOMAINS(3), .STAGGER(3), .DIV(1)
    ) u_dut_a (
        .CLK(clk), .RESETN(resetn_a), .soft_rst_req(soft_a),
        .rst_n_out(dom_a), .ce(ce_a), .ready(ready_a), .busy(busy_a)
    );

    reset_sequencer #(
        .SYNC_STAGES(2), .HOLD_CYCLES(4), .NUM_DOMAINS(3), .STAGGER(3), .DIV(4)
    ) u_dut_b (
        .CLK(clk), .RESETN(resetn_b), .soft_rst_req(soft_b),
        .rst_n_out(dom_b), .ce(ce_b), .ready(ready_b), .busy(busy_b)
    );

    reset_sequencer #(
        .SYNC_STAGES(2), .HOLD_CYCLES(1), .NUM_DOMAINS(1), .STAGGER(1), .DIV(1)
    ) u_dut_c (
        .CLK(clk), .RESETN(resetn_c), .soft_rst_req(soft_c),
        .rst_n_out(dom_c), .ce(ce_c), .ready(ready_c), .busy(busy_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at E%0d: got=%0h expected=%0h", tag, e, got, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic run_to(input int k);
        while (e < k) adv();
    endtask

    function automatic logic [2:0] exp_dom(input int k);
        if (k >= 11)     return 3'b111;
        else if (k >= 8) return 3'b011;
        else if (k >= 5) return 3'b001;
        else             return 3'b000;
    endfunction

    // Config A timeline: k counts edges from the (re)start of the sequence.
    task automatic check_a(input int k);
        $display("A  E%0d dom=%b ce=%b ready=%b busy=%b", e, dom_a, ce_a, ready_a, busy_a);
        check("a_dom",   32'(dom_a),   32'(exp_dom(k)));
        check("a_ce",    32'(ce_a),    32'(k >= 6));
        check("a_ready", 32'(ready_a), 32'(k >= 11));
        check("a_busy",  32'(busy_a),  32'(k < 11));
        check("a_no_x",  32'($isunknown({dom_a, ce_a, ready_a, busy_a})), 32'(0));
    endtask

    task automatic check_a_reset(input string tag);
        $display("A  %s dom=%b ce=%b ready=%b busy=%b", tag, dom_a, ce_a, ready_a, busy_a);
        check({tag, "_dom"},   32'(dom_a),   32'(0));
        check({tag, "_ce"},    32'(ce_a),    32'(0));
        check({tag, "_ready"}, 32'(ready_a), 32'(0));
        check({tag, "_busy"},  32'(busy_a),  32'(1));
    endtask

    initial begin
        resetn_a = 1'b0;
        resetn_b = 1'b0;
        resetn_c = 1'b0;
        soft_a   = 1'b0;
        soft_b   = 1'b0;
        soft_c   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_a_reset("rst_a");
        check("rst_b_dom",  32'(dom_b),  32'(0));
        check("rst_b_busy", 32'(busy_b), 32'(1));
        check("rst_c_dom",  32'(dom_c),  32'(0));
        check("rst_c_busy", 32'(busy_c), 32'(1));

        // Tests 1-3: A (DIV=1) and B (DIV=4) released together; soft pulse on A at E20.
        @(negedge clk);
        resetn_a = 1'b1;
        resetn_b = 1'b1;
        e = -1;
        for (int k = 0; k <= 31; k++) begin
            run_to(k);
            check_a((k < 20) ? k : k - 19);
            $display("B  E%0d dom=%b ce=%b ready=%b", e, dom_b, ce_b, ready_b);
            check("b_dom",   32'(dom_b),   32'(exp_dom(k)));
            check("b_ce",    32'(ce_b),    32'(k >= 9 && ((k - 9) % 4) == 0));
            check("b_ready", 32'(ready_b), 32'(k >= 11));
            if (k == 19) soft_a = 1'b1;
            if (k == 20) soft_a = 1'b0;
        end

        // Test 4: fresh run, RESETN dropped between E7 and E8.
        resetn_a = 1'b0;
        @(negedge clk);
        resetn_a = 1'b1;
        e = -1;
        for (int k = 0; k <= 7; k++) begin
            run_to(k);
            check_a(k);
        end
        #3;
        resetn_a = 1'b0;
        #1;
        check_a_reset("async_drop");
        @(negedge clk);
        resetn_a = 1'b1;
        e = -1;
        for (int k = 0; k <= 12; k++) begin
            run_to(k);
            check_a(k);
        end

        // Test 6: sub-cycle RESETN glitch while running.
        #1;
        resetn_a = 1'b0;
        #1;
        check_a_reset("glitch");
        #2;
        resetn_a = 1'b1;
        e = -1;
        for (int k = 0; k <= 12; k++) begin
            run_to(k);
            check_a(k);
        end

        // Test 5: single domain, H=1; soft request held for five sampled edges (E5..E9).
        @(negedge clk);
        resetn_c = 1'b1;
        e = -1;
        for (int k = 0; k <= 12; k++) begin
            run_to(k);
            $display("C  E%0d dom=%b ce=%b ready=%b busy=%b soft=%b", e, dom_c, ce_c, ready_c, busy_c, soft_c);
            check("c_dom",   32'(dom_c),   32'((k >= 2 && k < 5) || k >= 10));
            check("c_ready", 32'(ready_c), 32'((k >= 2 && k < 5) || k >= 10));
            check("c_busy",  32'(busy_c),  32'(!((k >= 2 && k < 5) || k >= 10)));
            check("c_ce",    32'(ce_c),    32'((k >= 3 && k < 5) || k >= 11));
            if (k == 4) soft_c = 1'b1;
            if (k == 9) soft_c = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
